// File: rtl/main_slave_loader_pkg.sv
// main_slave_loader shared types and defaults.
// Command ops, response status codes and loader FSM states.
package main_slave_loader_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int DATA_W_DEF      = 64;
    localparam int SIZE_W_DEF      = 7;
    localparam int CNT_W           = 32;
    localparam int RUN_TIMEOUT_DEF = 200000000;
    localparam int RD_TIMEOUT_DEF  = 16;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_START = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_TIMEOUT = 2'd1,
        STAT_BAD_OP  = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RUN  = 3'd3,
        RESP = 3'd4
    } state_e;

endpackage

// File: rtl/main_slave_loader_cycle_counter.sv
// Shared 32-bit cycle counter for read and run timeouts.
// Loads 1, increments on demand, flags when it equals the limit.
module loader_cycle_counter
    import main_slave_loader_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    // count register: load wins over increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/main_slave_loader.sv
// Host-side driver for the main accelerator slave port.
// Preloads memory, starts a run, times it, reads results back.
module main_slave_loader
    import main_slave_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SIZE_W      = SIZE_W_DEF,
    parameter int RUN_TIMEOUT = RUN_TIMEOUT_DEF,
    parameter int RD_TIMEOUT  = RD_TIMEOUT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [SIZE_W-1:0]   cmd_size,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                start_port,
    input  logic                done_port,
    output logic [1:0]          S_oe_ram,
    output logic [1:0]          S_we_ram,
    output logic [2*ADDR_W-1:0] S_addr_ram,
    output logic [2*DATA_W-1:0] S_Wdata_ram,
    output logic [2*SIZE_W-1:0] S_data_ram_size,
    input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]          Sout_DataRdy
);

    state_e              state, state_n;
    logic                idle_q;
    logic                oe_q, oe_n, we_q, we_n;
    logic                start_q, start_n;
    logic                rv_q, rv_n;
    status_e             status_q, status_n;
    logic [DATA_W-1:0]   rdata_q, rdata_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [SIZE_W-1:0]   size_q, size_n;
    logic                cnt_load, cnt_inc, cnt_hit;
    logic [CNT_W-1:0]    cnt, cnt_limit;
    logic                unused_inputs;

    assign unused_inputs = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W],
                             Sout_DataRdy[1]};

    assign cnt_limit = (state == RUN) ? CNT_W'(RUN_TIMEOUT)
                                      : CNT_W'(RD_TIMEOUT);

    loader_cycle_counter u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .limit    (cnt_limit),
        .count    (cnt),
        .at_limit (cnt_hit)
    );

    // state and every output register; outputs follow next-state decode
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idle_q   <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            start_q  <= 1'b0;
            rv_q     <= 1'b0;
            status_q <= STAT_OK;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
        end else begin
            state    <= state_n;
            idle_q   <= (state_n == IDLE);
            oe_q     <= oe_n;
            we_q     <= we_n;
            start_q  <= start_n;
            rv_q     <= rv_n;
            status_q <= status_n;
            rdata_q  <= rdata_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            size_q   <= size_n;
        end
    end

    // next state and next registered outputs, all zero unless driven
    always_comb begin
        state_n  = state;
        oe_n     = 1'b0;
        we_n     = 1'b0;
        start_n  = 1'b0;
        rv_n     = 1'b0;
        status_n = STAT_OK;
        rdata_n  = '0;
        addr_n   = '0;
        wdata_n  = '0;
        size_n   = '0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_WRITE: begin
                            state_n = WR;
                            we_n    = 1'b1;
                            addr_n  = cmd_addr;
                            wdata_n = cmd_data;
                            size_n  = cmd_size;
                        end
                        OP_READ: begin
                            state_n  = RD;
                            oe_n     = 1'b1;
                            addr_n   = cmd_addr;
                            size_n   = cmd_size;
                            cnt_load = 1'b1;
                        end
                        OP_START: begin
                            state_n  = RUN;
                            start_n  = 1'b1;
                            cnt_load = 1'b1;
                        end
                        OP_RSVD: begin
                            state_n  = RESP;
                            rv_n     = 1'b1;
                            status_n = STAT_BAD_OP;
                        end
                    endcase
                end
            end
            WR: begin
                state_n = RESP;
                rv_n    = 1'b1;
            end
            RD: begin
                if (Sout_DataRdy[0]) begin
                    state_n = RESP;
                    rv_n    = 1'b1;
                    rdata_n = Sout_Rdata_ram[DATA_W-1:0];
                end else if (cnt_hit) begin
                    state_n  = RESP;
                    rv_n     = 1'b1;
                    status_n = STAT_TIMEOUT;
                end else begin
                    oe_n    = 1'b1;
                    addr_n  = addr_q;
                    size_n  = size_q;
                    cnt_inc = 1'b1;
                end
            end
            RUN: begin
                if (done_port) begin
                    state_n = RESP;
                    rv_n    = 1'b1;
                    rdata_n = DATA_W'(cnt);
                end else if (cnt_hit) begin
                    state_n  = RESP;
                    rv_n     = 1'b1;
                    status_n = STAT_TIMEOUT;
                    rdata_n  = DATA_W'(cnt);
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end else begin
                    rv_n     = 1'b1;
                    status_n = status_q;
                    rdata_n  = rdata_q;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cmd_ready       = idle_q;
    assign rsp_valid       = rv_q;
    assign rsp_status      = status_q;
    assign rsp_data        = rdata_q;
    assign start_port      = start_q;
    assign S_oe_ram        = {1'b0, oe_q};
    assign S_we_ram        = {1'b0, we_q};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q};

endmodule

// File: tb/tb_main_slave_loader.sv
// Bench for main_slave_loader: cycle model plus directed vectors.
// Second instance exercises a short run timeout.
module tb_main_slave_loader;

    localparam int AW     = 10;
    localparam int DW     = 64;
    localparam int SW     = 7;
    localparam int RD_TO  = 16;
    localparam int RUN_TO = 200000000;

    logic            clock = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_data;
    logic [SW-1:0]   cmd_size;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_status;
    logic [DW-1:0]   rsp_data;
    logic            start_port, done_port;
    logic [1:0]      S_oe_ram, S_we_ram;
    logic [2*AW-1:0] S_addr_ram;
    logic [2*DW-1:0] S_Wdata_ram;
    logic [2*SW-1:0] S_data_ram_size;
    logic [2*DW-1:0] Sout_Rdata_ram = '0;
    logic [1:0]      Sout_DataRdy = 2'b10;
    logic [234:0]    all_out;

    logic            b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
    logic [1:0]      b_cmd_op, b_rsp_status, b_oe, b_we;
    logic [DW-1:0]   b_rsp_data;
    logic            b_start;
    logic [2*AW-1:0] b_addr;
    logic [2*DW-1:0] b_wdata;
    logic [2*SW-1:0] b_size;

    always #5 clock = ~clock;

    main_slave_loader u_dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    main_slave_loader #(.RUN_TIMEOUT(50)) u_dut50 (
        .clock(clock), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_addr(10'h0), .cmd_data(64'h0), .cmd_size(7'h0),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_status(b_rsp_status), .rsp_data(b_rsp_data),
        .start_port(b_start), .done_port(1'b0),
        .S_oe_ram(b_oe), .S_we_ram(b_we), .S_addr_ram(b_addr),
        .S_Wdata_ram(b_wdata), .S_data_ram_size(b_size),
        .Sout_Rdata_ram(128'h0), .Sout_DataRdy(2'b00)
    );

    assign all_out = {cmd_ready, rsp_valid, rsp_status, rsp_data, start_port,
                      S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
                      S_data_ram_size};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // slave memory model; channel 1 carries junk that must be ignored
    logic [DW-1:0] mem [0:1023];
    int rd_lat = -1;
    int oe_run = 0;
    int oe_cnt = 0;
    int st_cnt = 0;

    always @(negedge clock) begin
        if (S_we_ram[0]) mem[S_addr_ram[AW-1:0]] <= S_Wdata_ram[DW-1:0];
        if (S_oe_ram[0]) oe_cnt <= oe_cnt + 1;
        if (start_port) st_cnt <= st_cnt + 1;
        oe_run <= S_oe_ram[0] ? oe_run + 1 : 0;
        if (S_oe_ram[0] && rd_lat >= 0 && oe_run == rd_lat) begin
            Sout_DataRdy   <= 2'b11;
            Sout_Rdata_ram <= {64'hDEAD_BEEF_0BAD_F00D, mem[S_addr_ram[AW-1:0]]};
        end else begin
            Sout_DataRdy   <= 2'b10;
            Sout_Rdata_ram <= {64'hDEAD_BEEF_0BAD_F00D, 64'h5555_AAAA_5555_AAAA};
        end
    end

    // transaction model: t is the cycle index since acceptance,
    // m_end is the last working cycle once known
    logic          m_busy = 1'b0;
    logic          m_rdy = 1'b0;
    int            m_t = 0;
    int            m_end = -1;
    logic [1:0]    m_op = 2'd0;
    logic [1:0]    m_st = 2'd0;
    logic [DW-1:0] m_data = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [SW-1:0] m_size = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_end  <= -1;
            m_t    <= 0;
        end else begin
            m_rdy <= 1'b1;
            if (m_busy) begin
                m_t <= m_t + 1;
                if (m_end < 0) begin
                    if (m_op == 2'd0 && m_t == 1) begin
                        m_end <= 1; m_st <= 2'd0; m_data <= '0;
                    end else if (m_op == 2'd1) begin
                        if (Sout_DataRdy[0]) begin
                            m_end <= m_t; m_st <= 2'd0;
                            m_data <= Sout_Rdata_ram[DW-1:0];
                        end else if (m_t == RD_TO) begin
                            m_end <= m_t; m_st <= 2'd1; m_data <= '0;
                        end
                    end else if (m_op == 2'd2) begin
                        if (done_port) begin
                            m_end <= m_t; m_st <= 2'd0; m_data <= 64'(m_t);
                        end else if (m_t == RUN_TO) begin
                            m_end <= m_t; m_st <= 2'd1; m_data <= 64'(m_t);
                        end
                    end
                end else if (rsp_ready) begin
                    m_busy <= 1'b0;
                end
            end else if (m_rdy && cmd_valid) begin
                m_busy  <= 1'b1;
                m_t     <= 1;
                m_op    <= cmd_op;
                m_addr  <= cmd_addr;
                m_wdata <= cmd_data;
                m_size  <= cmd_size;
                m_data  <= '0;
                m_st    <= (cmd_op == 2'd3) ? 2'd2 : 2'd0;
                m_end   <= (cmd_op == 2'd3) ? 0 : -1;
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        logic e_we, e_oe, e_st, e_rv;
        e_we = m_busy && m_op == 2'd0 && m_t == 1;
        e_oe = m_busy && m_op == 2'd1 && m_end < 0;
        e_st = m_busy && m_op == 2'd2 && m_t == 1;
        e_rv = m_busy && m_end >= 0;
        chk("cyc_cmd_ready", cmd_ready, m_rdy && !m_busy);
        chk("cyc_we", S_we_ram, {1'b0, e_we});
        chk("cyc_oe", S_oe_ram, {1'b0, e_oe});
        chk("cyc_start", start_port, e_st);
        chk("cyc_addr", S_addr_ram, (e_we || e_oe) ? 20'(m_addr) : 20'h0);
        chk("cyc_size", S_data_ram_size, (e_we || e_oe) ? 14'(m_size) : 14'h0);
        chk("cyc_wdata", S_Wdata_ram, e_we ? 128'(m_wdata) : 128'h0);
        chk("cyc_rsp_valid", rsp_valid, e_rv);
        chk("cyc_rsp_status", rsp_status, e_rv ? m_st : 2'd0);
        chk("cyc_rsp_data", rsp_data, e_rv ? m_data : 64'h0);
    end

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n;
        n = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a;
        cmd_data = d; cmd_size = s;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int stall, output logic [1:0] st,
                           output logic [DW-1:0] d, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        chk("rsp_seen", rsp_valid, 1);
        repeat (stall) @(negedge clock);
        st = rsp_status;
        d  = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]    st;
        logic [DW-1:0] d;
        int lat, o0, s0;
        reset = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_size = 0;
        rsp_ready = 0; done_port = 0;
        b_cmd_valid = 0; b_cmd_op = 2'd2; b_rsp_ready = 0;
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_outs", all_out, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_ready", cmd_ready, 1);

        send(2'd0, 10'h005, 64'h1B, 7'd8);
        chk("wr_we", S_we_ram, 2'b01);
        chk("wr_addr", S_addr_ram, 20'h005);
        chk("wr_data", S_Wdata_ram, 128'h1B);
        chk("wr_size", S_data_ram_size, 14'd8);
        get_rsp(0, st, d, lat);
        chk("wr_lat", lat, 1);
        chk("wr_status", st, 0);

        rd_lat = 2; o0 = oe_cnt;
        send(2'd1, 10'h005, 64'h0, 7'd8);
        get_rsp(2, st, d, lat);
        chk("rd_lat", lat, 3);
        chk("rd_status", st, 0);
        chk("rd_data", d, 64'h1B);
        chk("rd_oe_cycles", oe_cnt - o0, 3);

        rd_lat = -1; o0 = oe_cnt;
        send(2'd1, 10'h005, 64'h0, 7'd8);
        get_rsp(0, st, d, lat);
        chk("rdto_lat", lat, 16);
        chk("rdto_status", st, 1);
        chk("rdto_data", d, 0);
        chk("rdto_oe_cycles", oe_cnt - o0, 16);

        rd_lat = 15;
        send(2'd1, 10'h005, 64'h0, 7'd8);
        get_rsp(0, st, d, lat);
        chk("rd_last_lat", lat, 16);
        chk("rd_last_status", st, 0);
        chk("rd_last_data", d, 64'h1B);

        send(2'd0, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
        get_rsp(0, st, d, lat);
        rd_lat = 0;
        send(2'd1, 10'h3FF, 64'h0, 7'd64);
        get_rsp(0, st, d, lat);
        chk("rd0_lat", lat, 1);
        chk("rd0_data", d, 64'hFFFF_FFFF_FFFF_FFFF);

        s0 = st_cnt;
        send(2'd2, 10'h0, 64'h0, 7'd0);
        repeat (99) @(negedge clock);
        done_port = 1'b1;
        @(negedge clock);
        done_port = 1'b0;
        get_rsp(1, st, d, lat);
        chk("run_lat", lat, 0);
        chk("run_status", st, 0);
        chk("run_count", d, 100);
        chk("run_start_cycles", st_cnt - s0, 1);

        done_port = 1'b1;
        repeat (3) @(negedge clock);
        done_port = 1'b0;
        chk("idle_done_ignored", {rsp_valid, start_port, cmd_ready}, 3'b001);

        o0 = oe_cnt;
        send(2'd3, 10'h155, 64'hABCD, 7'd16);
        get_rsp(0, st, d, lat);
        chk("bad_lat", lat, 0);
        chk("bad_status", st, 2);
        chk("bad_data", d, 0);
        chk("bad_no_oe", oe_cnt - o0, 0);

        send(2'd2, 10'h0, 64'h0, 7'd0);
        chk("run2_start", start_port, 1);
        #2 reset = 1'b1;
        #1 chk("rst_run_outs", all_out, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_run_ready", cmd_ready, 1);

        send(2'd0, 10'h02A, 64'h77, 7'd8);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("stall_valid", rsp_valid, 1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("rst_resp_outs", all_out, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_resp_ready", cmd_ready, 1);

        send(2'd0, 10'h02A, 64'h99, 7'd8);
        chk("wr2_we", S_we_ram, 2'b01);
        chk("wr2_data", S_Wdata_ram, 128'h99);
        get_rsp(0, st, d, lat);
        chk("wr2_status", st, 0);
        rd_lat = 1;
        send(2'd1, 10'h02A, 64'h0, 7'd8);
        get_rsp(0, st, d, lat);
        chk("rd2_data", d, 64'h99);

        @(negedge clock);
        b_cmd_valid = 1'b1;
        lat = 0;
        while (!b_cmd_ready && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("b_ready", b_cmd_ready, 1);
        @(negedge clock);
        b_cmd_valid = 1'b0;
        chk("b_start", b_start, 1);
        lat = 0;
        while (!b_rsp_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        chk("b_lat", lat, 50);
        chk("b_status", b_rsp_status, 1);
        chk("b_count", b_rsp_data, 50);
        b_rsp_ready = 1'b1;
        @(negedge clock);
        b_rsp_ready = 1'b0;
        chk("b_idle", {b_cmd_ready, b_rsp_valid}, 2'b10);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
